uart_cmd_ctrl: RTL and testbench

Command controller between the UART receiver and the counter. It decodes received ASCII command bytes into the counter's `enable`/`clear`/`mode` controls and queues an echo/acknowledge byte for the UART transmitter. It replaces the ad-hoc decode inside the UART top level: `uart_rx` feeds it, while `counter_top` and `uart_tx` consume its outputs.

---
 rtl/uart_cmd_pkg.sv | 30 +++
 rtl/uart_cmd_ctrl_fifo.sv | 60 ++++++
 rtl/uart_cmd_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, TX state encoding and helpers for the UART command controller.
package uart_cmd_pkg;

  // Command bytes are stored in lower case; decode folds the input first.
  localparam logic [7:0] CMD_RUN  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_CLR  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_MODE = 8'h6D;  // 'm'
  localparam logic [7:0] CHR_NAK  = 8'h3F;  // '?'
  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;

  // Cycles WAIT_BUSY tolerates tx_busy staying low before giving up on the frame.
  localparam int TX_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  // Fold ASCII 'A'..'Z' onto 'a'..'z'; every other byte passes through.
  function automatic logic [7:0] to_lower(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) begin
      return b | 8'h20;
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_fifo.sv
// Small synchronous FIFO holding echo bytes waiting for the UART transmitter.
// The head is presented combinationally so the TX FSM can latch it directly.
module cmd_echo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign dout  = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because count_reg gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Decodes UART command bytes into counter controls and queues echo/ack bytes
// for the UART transmitter through a small FIFO and a handshake FSM.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter bit ECHO_EN    = 1'b1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       o_enable,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_err
);

  logic [7:0] cmd_lc;
  logic       is_run, is_clr, is_mode, is_ign, is_known;
  logic       needs_echo, overflow;
  logic [7:0] echo_byte;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  logic       enable_reg, mode_reg, clear_reg, err_reg;
  logic       tx_start_reg;
  logic [7:0] tx_data_reg;
  tx_state_t  state_reg, state_next;
  logic [1:0] wait_cnt_reg, wait_cnt_next;

  // Command classification of the byte on rx_data.
  always_comb begin
    cmd_lc     = to_lower(rx_data);
    is_run     = (cmd_lc == CMD_RUN);
    is_clr     = (cmd_lc == CMD_CLR);
    is_mode    = (cmd_lc == CMD_MODE);
    is_ign     = (rx_data == CHR_CR) || (rx_data == CHR_LF);
    is_known   = is_run || is_clr || is_mode;
    needs_echo = ECHO_EN && rx_done && !is_ign;
    echo_byte  = is_known ? rx_data : CHR_NAK;
  end

  // Pop happens in START; a full FIFO only drops the push when no pop frees a slot.
  assign fifo_pop  = (state_reg == START);
  assign overflow  = needs_echo && fifo_full && !fifo_pop;
  assign fifo_push = needs_echo && !rst;

  cmd_echo_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (echo_byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Registered decode: level toggles and one-cycle pulses land the cycle after rx_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_reg <= 1'b0;
      mode_reg   <= 1'b0;
      clear_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      clear_reg <= rx_done && is_clr;
      err_reg   <= (rx_done && !is_known && !is_ign) || overflow;
      if (rx_done && is_run)  enable_reg <= ~enable_reg;
      if (rx_done && is_mode) mode_reg   <= ~mode_reg;
    end
  end

  // TX handshake next-state logic with a bounded wait for tx_busy to rise.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        wait_cnt_next = '0;
        if (ECHO_EN && !fifo_empty && !tx_busy) state_next = START;
      end
      START: begin
        wait_cnt_next = '0;
        state_next    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt_reg == 2'(TX_TIMEOUT - 1)) begin
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // TX state register; start pulse and head byte are registered on entry to START.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      tx_start_reg <= (state_next == START);
      if (state_next == START && state_reg == IDLE) tx_data_reg <= fifo_dout;
    end
  end

  assign o_enable = enable_reg;
  assign o_mode   = mode_reg;
  assign o_clear  = clear_reg;
  assign o_err    = err_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a behavioural uart_tx busy model.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int BUSY_LEN = 10;  // shortened frame time for simulation

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       o_enable, o_clear, o_mode, o_err;

  logic       man_busy = 1'b0;
  logic       auto_en  = 1'b1;
  int         busy_left = 0;
  int         cyc = 0;
  int         err_cnt = 0;
  int         clr_cnt = 0;
  logic [7:0] log_q[$];
  int         start_cyc[$];

  int tests = 0;
  int fails = 0;
  int e0, c0, n0, k;

  uart_cmd_ctrl #(.ECHO_EN(1'b1), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .o_enable (o_enable),
    .o_clear  (o_clear),
    .o_mode   (o_mode),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  assign tx_busy = man_busy | (busy_left != 0);

  // uart_tx model and output monitor; samples the values of the cycle just ended.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      log_q.push_back(tx_data);
      start_cyc.push_back(cyc);
      $display("[TB] cycle %0d tx_start data=%02h", cyc, tx_data);
      if (auto_en) busy_left <= BUSY_LEN;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
    if (o_err)   err_cnt <= err_cnt + 1;
    if (o_clear) clr_cnt <= clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    start_cyc.delete();
  endtask

  task automatic wait_log(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && log_q.size() < n; i++) @(negedge clk);
    check(tag, log_q.size(), n);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_enable", o_enable, 0);
    check("rst_mode", o_mode, 0);
    check("rst_clear", o_clear, 0);
    check("rst_err", o_err, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_fifo_empty", dut.fifo_empty, 1);
    rst = 1'b0;

    // First command: enable next cycle, echo start one cycle later
    send(8'h72);
    check("t1_enable", o_enable, 1);
    check("t1_no_start_yet", tx_start, 0);
    @(negedge clk);
    check("t1_tx_start", tx_start, 1);
    check("t1_tx_data", tx_data, 8'h72);
    wait_log("t1_echo_cnt", 1, 50);
    repeat (BUSY_LEN + 5) @(negedge clk);

    // R, c, M back-to-back
    do_reset();
    c0 = clr_cnt;
    e0 = err_cnt;
    send(8'h52);
    check("t2_enable", o_enable, 1);
    send(8'h63);
    check("t2_clear_pulse", o_clear, 1);
    check("t2_enable_kept", o_enable, 1);
    send(8'h4D);
    check("t2_clear_end", o_clear, 0);
    check("t2_mode", o_mode, 1);
    wait_log("t2_echo_cnt", 3, 200);
    if (log_q.size() >= 3) begin
      check("t2_echo0", log_q[0], 8'h52);
      check("t2_echo1", log_q[1], 8'h63);
      check("t2_echo2", log_q[2], 8'h4D);
    end
    check("t2_clear_count", clr_cnt - c0, 1);
    check("t2_no_err", err_cnt - e0, 0);

    // Unknown byte, then CR/LF
    e0 = err_cnt;
    send(8'h41);
    check("t3_err_pulse", o_err, 1);
    check("t3_enable_kept", o_enable, 1);
    check("t3_mode_kept", o_mode, 1);
    @(negedge clk);
    check("t3_err_end", o_err, 0);
    wait_log("t3_nak_cnt", 4, 100);
    if (log_q.size() >= 4) check("t3_nak", log_q[3], 8'h3F);
    repeat (BUSY_LEN + 5) @(negedge clk);
    send(8'h0D);
    send(8'h0A);
    repeat (30) @(negedge clk);
    check("t3_crlf_no_echo", log_q.size(), 4);
    check("t3_crlf_no_err", err_cnt - e0, 1);

    // Overflow: six r while transmitter busy
    do_reset();
    man_busy = 1'b1;
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      send(8'h72);
      @(negedge clk);
    end
    check("t4_enable", o_enable, 0);
    check("t4_err_count", err_cnt - e0, 2);
    check("t4_fifo_full", dut.fifo_full, 1);
    check("t4_no_tx", log_q.size(), 0);
    man_busy = 1'b0;
    wait_log("t4_echo_cnt", 4, 4 * (BUSY_LEN + 8));
    repeat (30) @(negedge clk);
    check("t4_echo_exact", log_q.size(), 4);
    for (k = 0; k < 4 && k < log_q.size(); k++) check("t4_echo_val", log_q[k], 8'h72);

    // tx_busy never rises: timeout then next byte
    repeat (BUSY_LEN + 5) @(negedge clk);
    auto_en = 1'b0;
    do_reset();
    send(8'h72);
    send(8'h6D);
    wait_log("t5_start_cnt", 2, 60);
    if (start_cyc.size() >= 2) begin
      check("t5_retry_gap", start_cyc[1] - start_cyc[0], 6);
      check("t5_second_byte", log_q[1], 8'h6D);
    end

    // Reset while in WAIT_DONE with two bytes queued
    auto_en = 1'b1;
    repeat (10) @(negedge clk);
    do_reset();
    send(8'h72);
    send(8'h72);
    send(8'h72);
    for (int i = 0; i < 20 && dut.state_reg != WAIT_DONE; i++) @(negedge clk);
    check("t6_in_wait_done", 32'(dut.state_reg), 32'(WAIT_DONE));
    check("t6_fifo_nonempty", dut.fifo_empty, 0);
    n0 = log_q.size();
    rst = 1'b1;
    @(negedge clk);
    check("t6_fifo_flushed", dut.fifo_empty, 1);
    check("t6_tx_start", tx_start, 0);
    check("t6_enable", o_enable, 0);
    check("t6_state_idle", 32'(dut.state_reg), 32'(IDLE));
    rst = 1'b0;
    repeat (BUSY_LEN + 30) @(negedge clk);
    check("t6_no_echo_after", log_q.size(), n0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
